// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the instruction/data memory bus arbiter.
// The arbiter states, requester owner and bus size codes are defined here.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } bus_size_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// SRAM-like memory bus between the arbiter (master) and the memory system (slave).
// A transaction is an address phase closed by bus_addr_ok, then a data phase closed by bus_data_ok.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_wr,
    output bus_size,
    output bus_addr,
    output bus_wdata,
    input  bus_addr_ok,
    input  bus_data_ok,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_wr,
    input  bus_size,
    input  bus_addr,
    input  bus_wdata,
    output bus_addr_ok,
    output bus_data_ok,
    output bus_rdata
  );

endinterface

// File: rtl/bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data memory, one transaction at a time, data first.
// Define BUS_ARB_PERF_EN to add completed-transaction and stall-cycle counter outputs.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pipe_stall,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              stallreq_from_if,
  output logic              stallreq_from_mem,
`ifdef BUS_ARB_PERF_EN
  output logic [31:0]       perf_inst_cnt,
  output logic [31:0]       perf_data_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  bus_arbiter_if.master     bus
);

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  logic              discard_q;
  logic              bus_req_q;
  logic              bus_wr_q;
  bus_size_e         bus_size_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;

  logic              inst_done_q, inst_done_d;
  logic              data_done_q, data_done_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              inst_fin, data_fin;

  // A fetch killed by flush, earlier in flight or in its completion cycle, never reaches the stage.
  always_comb begin
    inst_fin = 1'b0;
    data_fin = 1'b0;
    if (state_q == ARB_WAIT && bus.bus_data_ok) begin
      if (owner_q == OWN_DATA) begin
        data_fin = 1'b1;
      end else if (!discard_q && !flush) begin
        inst_fin = 1'b1;
      end
    end

    inst_done_d = inst_done_q;
    if (inst_done_q && !pipe_stall) inst_done_d = 1'b0;
    if (flush)                      inst_done_d = 1'b0;
    if (inst_fin)                   inst_done_d = 1'b1;

    data_done_d = data_done_q;
    if (data_done_q && !pipe_stall) data_done_d = 1'b0;
    if (data_fin)                   data_done_d = 1'b1;

    inst_rdata_d = inst_fin ? bus.bus_rdata : inst_rdata_q;
    data_rdata_d = data_fin ? bus.bus_rdata : data_rdata_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Bus fields are latched at issue so they stay stable for the whole address phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_INST;
      discard_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_size_q  <= SIZE_BYTE;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      if (flush && owner_q == OWN_INST && state_q != ARB_IDLE) discard_q <= 1'b1;
      case (state_q)
        ARB_IDLE: begin
          if (data_req && !data_done_q) begin
            owner_q     <= OWN_DATA;
            bus_req_q   <= 1'b1;
            bus_wr_q    <= data_wr;
            bus_size_q  <= bus_size_e'(data_size);
            bus_addr_q  <= data_addr;
            bus_wdata_q <= data_wdata;
            state_q     <= ARB_ADDR;
          end else if (inst_req && !inst_done_q && !flush) begin
            owner_q     <= OWN_INST;
            bus_req_q   <= 1'b1;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= SIZE_WORD;
            bus_addr_q  <= inst_addr;
            bus_wdata_q <= '0;
            state_q     <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (bus.bus_addr_ok) begin
            bus_req_q <= 1'b0;
            state_q   <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (bus.bus_data_ok) begin
            if (owner_q == OWN_INST) discard_q <= 1'b0;
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          bus_req_q <= 1'b0;
          state_q   <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_wr    = bus_wr_q;
  assign bus.bus_size  = bus_size_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

  assign inst_rdata        = inst_rdata_q;
  assign data_rdata        = data_rdata_q;
  assign stallreq_from_if  = inst_req && !inst_done_q;
  assign stallreq_from_mem = data_req && !data_done_q;

`ifdef BUS_ARB_PERF_EN
  logic [31:0] perf_inst_q, perf_data_q, perf_stall_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_inst_q  <= '0;
      perf_data_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (inst_fin) perf_inst_q <= perf_inst_q + 32'd1;
      if (data_fin) perf_data_q <= perf_data_q + 32'd1;
      if (stallreq_from_if || stallreq_from_mem) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_inst_cnt  = perf_inst_q;
  assign perf_data_cnt  = perf_data_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed bus/requester vectors, a transaction-level
// reference model compared every cycle, and hand-computed literal expectations.
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          pipe_stall, flush, inst_req, data_req, data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] inst_addr, data_addr;
  logic [DW-1:0] data_wdata, inst_rdata, data_rdata;
  logic          stallreq_from_if, stallreq_from_mem;
`ifdef BUS_ARB_PERF_EN
  logic [31:0]   perfInstCnt, perfDataCnt, perfStallCnt;
`endif

  bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) busIf ();

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .pipe_stall        (pipe_stall),
    .flush             (flush),
    .inst_req          (inst_req),
    .inst_addr         (inst_addr),
    .inst_rdata        (inst_rdata),
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_size         (data_size),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_rdata        (data_rdata),
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_mem (stallreq_from_mem),
`ifdef BUS_ARB_PERF_EN
    .perf_inst_cnt     (perfInstCnt),
    .perf_data_cnt     (perfDataCnt),
    .perf_stall_cnt    (perfStallCnt),
`endif
    .bus               (busIf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pipeStall;
    logic        flush;
    logic        instReq;
    logic [31:0] instAddr;
    logic        dataReq;
    logic        dataWr;
    logic [1:0]  dataSize;
    logic [31:0] dataAddr;
    logic [31:0] dataWdata;
    logic        addrOk;
    logic        dataOk;
    logic [31:0] rdata;
  } stim_t;

  stim_t s;
  int    testsRun = 0;
  int    failCount = 0;
  bit    cmpEn = 1'b0;

  // Reference model: at most one pending transaction, described by what it asks for and how far it got.
  bit          mBusy = 1'b0;
  bit          mAccepted = 1'b0;
  bit          mIsData = 1'b0;
  bit          mKilled = 1'b0;
  bit          mWr = 1'b0;
  logic [1:0]  mSize = 2'd0;
  logic [31:0] mAddr = '0;
  logic [31:0] mWdata = '0;
  bit          mInstDone = 1'b0;
  bit          mDataDone = 1'b0;
  logic [31:0] mInstWord = '0;
  logic [31:0] mDataWord = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic driveInputs(input stim_t v);
    pipe_stall        = v.pipeStall;
    flush             = v.flush;
    inst_req          = v.instReq;
    inst_addr         = v.instAddr;
    data_req          = v.dataReq;
    data_wr           = v.dataWr;
    data_size         = v.dataSize;
    data_addr         = v.dataAddr;
    data_wdata        = v.dataWdata;
    busIf.bus_addr_ok = v.addrOk;
    busIf.bus_data_ok = v.dataOk;
    busIf.bus_rdata   = v.rdata;
  endtask

  // Drive one cycle's inputs just after the rising edge, then return at the falling edge.
  task automatic applyStimulus(input stim_t v);
    @(posedge clk);
    #1;
    driveInputs(v);
    @(negedge clk);
  endtask

  // Inputs are stable from just after one rising edge to the next, so at the falling edge they equal
  // what the DUT samples at the coming edge: compare first, then advance the model by that edge.
  task automatic modelStep();
    bit instDoneWas, dataDoneWas, reqExp;
    if (!resetn) begin
      mBusy = 0; mAccepted = 0; mIsData = 0; mKilled = 0; mWr = 0;
      mSize = '0; mAddr = '0; mWdata = '0;
      mInstDone = 0; mDataDone = 0; mInstWord = '0; mDataWord = '0;
    end
    reqExp = mBusy && !mAccepted;
    checkOutput("m_stall_if", 32'(stallreq_from_if), 32'(inst_req && !mInstDone));
    checkOutput("m_stall_mem", 32'(stallreq_from_mem), 32'(data_req && !mDataDone));
    checkOutput("m_inst_rdata", inst_rdata, mInstWord);
    checkOutput("m_data_rdata", data_rdata, mDataWord);
    checkOutput("m_bus_req", 32'(busIf.bus_req), 32'(reqExp));
    if (reqExp) begin
      checkOutput("m_bus_addr", busIf.bus_addr, mAddr);
      checkOutput("m_bus_wr", 32'(busIf.bus_wr), 32'(mIsData ? mWr : 1'b0));
      checkOutput("m_bus_size", 32'(busIf.bus_size), 32'(mIsData ? mSize : 2'd2));
      if (mIsData) checkOutput("m_bus_wdata", busIf.bus_wdata, mWdata);
    end
    if (!resetn) return;

    instDoneWas = mInstDone;
    dataDoneWas = mDataDone;
    if (!pipe_stall || flush) mInstDone = 0;
    if (!pipe_stall)          mDataDone = 0;
    if (mBusy && !mIsData && flush) mKilled = 1;

    if (mBusy && mAccepted) begin
      if (busIf.bus_data_ok) begin
        if (mIsData) begin
          mDataWord = busIf.bus_rdata;
          mDataDone = 1;
        end else if (!mKilled) begin
          mInstWord = busIf.bus_rdata;
          mInstDone = 1;
        end
        mBusy   = 0;
        mKilled = 0;
      end
    end else if (mBusy) begin
      if (busIf.bus_addr_ok) mAccepted = 1;
    end else if (data_req && !dataDoneWas) begin
      mBusy = 1; mAccepted = 0; mIsData = 1; mKilled = 0;
      mAddr = data_addr; mWr = data_wr; mSize = data_size; mWdata = data_wdata;
    end else if (inst_req && !instDoneWas && !flush) begin
      mBusy = 1; mAccepted = 0; mIsData = 0; mKilled = 0;
      mAddr = inst_addr;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmpEn) modelStep();
    end
  end

  initial begin
    s = '0;
    driveInputs(s);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_bus_req", 32'(busIf.bus_req), 32'd0);
    checkOutput("rst_bus_wr", 32'(busIf.bus_wr), 32'd0);
    checkOutput("rst_bus_size", 32'(busIf.bus_size), 32'd0);
    checkOutput("rst_bus_addr", busIf.bus_addr, 32'd0);
    checkOutput("rst_bus_wdata", busIf.bus_wdata, 32'd0);
    checkOutput("rst_inst_rdata", inst_rdata, 32'd0);
    checkOutput("rst_data_rdata", data_rdata, 32'd0);
    checkOutput("rst_stall_if", 32'(stallreq_from_if), 32'd0);
    #2 resetn = 1'b1;
    cmpEn = 1'b1;

    // Fetch only, minimum latency.
    s.instReq = 1; s.instAddr = 32'hBFC0_0000;
    applyStimulus(s);
    checkOutput("f_c0_stall_if", 32'(stallreq_from_if), 32'd1);
    checkOutput("f_c0_bus_req", 32'(busIf.bus_req), 32'd0);
    s.addrOk = 1;
    applyStimulus(s);
    checkOutput("f_c1_bus_req", 32'(busIf.bus_req), 32'd1);
    checkOutput("f_c1_bus_addr", busIf.bus_addr, 32'hBFC0_0000);
    checkOutput("f_c1_stall_if", 32'(stallreq_from_if), 32'd1);
    s.addrOk = 0; s.dataOk = 1; s.rdata = 32'h3C08_0001;
    applyStimulus(s);
    checkOutput("f_c2_bus_req", 32'(busIf.bus_req), 32'd0);
    checkOutput("f_c2_stall_if", 32'(stallreq_from_if), 32'd1);
    s.dataOk = 0; s.rdata = '0;
    applyStimulus(s);
    checkOutput("f_c3_stall_if", 32'(stallreq_from_if), 32'd0);
    checkOutput("f_c3_inst_rdata", inst_rdata, 32'h3C08_0001);
    s.instReq = 0;
    applyStimulus(s);

    // Store and fetch together: data owns the bus first.
    s.dataReq = 1; s.dataWr = 1; s.dataSize = 2'd2; s.dataAddr = 32'h8000_0010; s.dataWdata = 32'hDEAD_BEEF;
    s.instReq = 1; s.instAddr = 32'hBFC0_0004;
    applyStimulus(s);
    checkOutput("b_c0_stall_mem", 32'(stallreq_from_mem), 32'd1);
    s.addrOk = 1;
    applyStimulus(s);
    checkOutput("b_c1_bus_wr", 32'(busIf.bus_wr), 32'd1);
    checkOutput("b_c1_bus_addr", busIf.bus_addr, 32'h8000_0010);
    checkOutput("b_c1_bus_wdata", busIf.bus_wdata, 32'hDEAD_BEEF);
    s.addrOk = 0; s.dataOk = 1;
    applyStimulus(s);
    s.dataOk = 0;
    applyStimulus(s);
    checkOutput("b_c3_stall_mem", 32'(stallreq_from_mem), 32'd0);
    checkOutput("b_c3_stall_if", 32'(stallreq_from_if), 32'd1);
    s.dataReq = 0; s.addrOk = 1;
    applyStimulus(s);
    checkOutput("b_c4_bus_req", 32'(busIf.bus_req), 32'd1);
    checkOutput("b_c4_bus_addr", busIf.bus_addr, 32'hBFC0_0004);
    checkOutput("b_c4_bus_wr", 32'(busIf.bus_wr), 32'd0);
    s.addrOk = 0; s.dataOk = 1; s.rdata = 32'h8C02_0000;
    applyStimulus(s);
    s.dataOk = 0; s.rdata = '0;
    applyStimulus(s);
    checkOutput("b_c6_stall_if", 32'(stallreq_from_if), 32'd0);
    checkOutput("b_c6_inst_rdata", inst_rdata, 32'h8C02_0000);
    s.instReq = 0;
    applyStimulus(s);

    // Flush while the fetch waits for data: its result is dropped, the redirected fetch proceeds.
    s.instReq = 1; s.instAddr = 32'hBFC0_0008;
    applyStimulus(s);
    s.addrOk = 1;
    applyStimulus(s);
    s.addrOk = 0; s.flush = 1;
    applyStimulus(s);
    checkOutput("x_c2_bus_req", 32'(busIf.bus_req), 32'd0);
    s.flush = 0; s.dataOk = 1; s.rdata = 32'hBAD0_BAD0; s.instAddr = 32'hBFC0_0380;
    applyStimulus(s);
    s.dataOk = 0; s.rdata = '0;
    applyStimulus(s);
    checkOutput("x_c4_inst_rdata", inst_rdata, 32'h8C02_0000);
    checkOutput("x_c4_stall_if", 32'(stallreq_from_if), 32'd1);
    s.addrOk = 1;
    applyStimulus(s);
    checkOutput("x_c5_bus_req", 32'(busIf.bus_req), 32'd1);
    checkOutput("x_c5_bus_addr", busIf.bus_addr, 32'hBFC0_0380);
    s.addrOk = 0; s.dataOk = 1; s.rdata = 32'h2408_0002;
    applyStimulus(s);
    s.dataOk = 0; s.rdata = '0;
    applyStimulus(s);
    checkOutput("x_c7_inst_rdata", inst_rdata, 32'h2408_0002);
    checkOutput("x_c7_stall_if", 32'(stallreq_from_if), 32'd0);
    s.instReq = 0;
    applyStimulus(s);

    // Load completes under a 4-cycle pipeline stall, then a byte store with a slow address phase.
    s.dataReq = 1; s.dataWr = 0; s.dataSize = 2'd2; s.dataAddr = 32'h8000_0020; s.dataWdata = '0;
    applyStimulus(s);
    s.addrOk = 1;
    applyStimulus(s);
    s.addrOk = 0; s.dataOk = 1; s.rdata = 32'hCAFE_F00D; s.pipeStall = 1;
    applyStimulus(s);
    s.dataOk = 0; s.rdata = '0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(s);
      checkOutput("p_hold_stall_mem", 32'(stallreq_from_mem), 32'd0);
      checkOutput("p_hold_bus_req", 32'(busIf.bus_req), 32'd0);
      checkOutput("p_hold_data_rdata", data_rdata, 32'hCAFE_F00D);
    end
    s.pipeStall = 0;
    applyStimulus(s);
    checkOutput("p_c7_stall_mem", 32'(stallreq_from_mem), 32'd0);
    s.dataWr = 1; s.dataSize = 2'd0; s.dataAddr = 32'h8000_0033; s.dataWdata = 32'h0000_00AB;
    applyStimulus(s);
    checkOutput("p_c8_stall_mem", 32'(stallreq_from_mem), 32'd1);
    checkOutput("p_c8_bus_req", 32'(busIf.bus_req), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) s.dataAddr = 32'h1234_5678;
      applyStimulus(s);
      checkOutput("d_slow_bus_req", 32'(busIf.bus_req), 32'd1);
      checkOutput("d_slow_bus_addr", busIf.bus_addr, 32'h8000_0033);
      checkOutput("d_slow_bus_size", 32'(busIf.bus_size), 32'd0);
      checkOutput("d_slow_bus_wdata", busIf.bus_wdata, 32'h0000_00AB);
    end
    s.addrOk = 1;
    applyStimulus(s);
    checkOutput("d_acc_bus_req", 32'(busIf.bus_req), 32'd1);
    s.addrOk = 0; s.dataOk = 1; s.rdata = 32'h55AA_55AA;
    applyStimulus(s);
    s.dataOk = 0; s.rdata = '0;
    applyStimulus(s);
    checkOutput("d_done_stall_mem", 32'(stallreq_from_mem), 32'd0);
    checkOutput("d_done_data_rdata", data_rdata, 32'h55AA_55AA);
    s.dataReq = 0;
    applyStimulus(s);

    // Reset while waiting for fetch data; a late data_ok after release is ignored.
    s.instReq = 1; s.instAddr = 32'hBFC0_0010;
    applyStimulus(s);
    s.addrOk = 1;
    applyStimulus(s);
    s.addrOk = 0;
    applyStimulus(s);
    checkOutput("r_wait_bus_req", 32'(busIf.bus_req), 32'd0);
    #2;
    s = '0;
    driveInputs(s);
    resetn = 1'b0;
    #1;
    checkOutput("r_async_bus_addr", busIf.bus_addr, 32'd0);
    checkOutput("r_async_bus_size", 32'(busIf.bus_size), 32'd0);
    checkOutput("r_async_inst_rdata", inst_rdata, 32'd0);
    checkOutput("r_async_data_rdata", data_rdata, 32'd0);
    checkOutput("r_async_stall_if", 32'(stallreq_from_if), 32'd0);
    @(negedge clk);
    #2 resetn = 1'b1;
    s.dataOk = 1; s.rdata = 32'hFFFF_FFFF;
    applyStimulus(s);
    s.dataOk = 0; s.rdata = '0;
    applyStimulus(s);
    checkOutput("r_late_inst_rdata", inst_rdata, 32'd0);
    checkOutput("r_late_data_rdata", data_rdata, 32'd0);
    checkOutput("r_late_bus_req", 32'(busIf.bus_req), 32'd0);
    s.instReq = 1; s.instAddr = 32'hBFC0_0014;
    applyStimulus(s);
    checkOutput("r_new_stall_if", 32'(stallreq_from_if), 32'd1);
    s.addrOk = 1;
    applyStimulus(s);
    checkOutput("r_new_bus_req", 32'(busIf.bus_req), 32'd1);
    checkOutput("r_new_bus_addr", busIf.bus_addr, 32'hBFC0_0014);
    s.addrOk = 0; s.dataOk = 1; s.rdata = 32'h0000_1234;
    applyStimulus(s);
    s.dataOk = 0; s.rdata = '0;
    applyStimulus(s);
    checkOutput("r_new_inst_rdata", inst_rdata, 32'h0000_1234);
    s.instReq = 0;
    applyStimulus(s);
    applyStimulus(s);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single SRAM-like memory bus between the instruction-fetch requester and the data-memory requester.
- Sequences one outstanding bus transaction at a time with a small state machine. Data has priority.
- Generates stallreq_from_if and stallreq_from_mem, which the hazard unit consumes.
- Holds completed results across global pipeline stalls and discards fetches killed by an exception flush.

Parameters:
ADDR_W, 32, address width of requesters and bus
DATA_W, 32, data width of requesters and bus

Ports:
clk  in  1  clock; all state on rising edge
resetn  in  1  asynchronous active-low reset
pipe_stall  in  1  global pipeline stall (wb_stall level); completed results are held while high
flush  in  1  exception flush; kills the in-flight or completed fetch result
inst_req  in  1  fetch request, level, held until the stage advances
inst_addr  in  ADDR_W  fetch address
inst_rdata  out  DATA_W  fetched word (registered)
data_req  in  1  data request, level
data_wr  in  1  1 = store
data_size  in  2  0 byte, 1 half, 2 word
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  store data
data_rdata  out  DATA_W  load data (registered)
stallreq_from_if  out  1  inst_req and fetch not done
stallreq_from_mem  out  1  data_req and data not done
bus_req  out  1  bus request
bus_wr  out  1  bus write
bus_size  out  2  bus size
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_addr_ok  in  1  address accepted
bus_data_ok  in  1  transaction complete; rdata valid
bus_rdata  in  DATA_W  bus read data

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; owner, inst_done, data_done and discard = 0.
  - All bus_* outputs = 0; inst_rdata = data_rdata = 0.
- States:
  - IDLE:
    - If data_req && !data_done: latch data fields, owner=DATA, go to ADDR.
    - Else if inst_req && !inst_done && !flush: latch inst_addr, owner=INST, go to ADDR.
  - ADDR:
    - bus_req=1, with bus fields taken from the latched registers. Fetch drives wr=0, size=2.
    - On bus_addr_ok, go to WAIT. The request is never withdrawn before addr_ok.
  - WAIT:
    - bus_req=0.
    - On bus_data_ok: capture bus_rdata into the owner's rdata register and set the owner's done flag.
    - If owner=INST and discard=1: do not update inst_rdata or inst_done; clear discard.
    - Then go to IDLE.
- bus_data_ok in ADDR or IDLE is ignored; the bus guarantees data_ok at least 1 cycle after addr_ok.
- Done flags:
  - done && !pipe_stall clears done at the next edge (the stage consumed the result).
  - flush clears inst_done. data_done is never cleared by flush, because the mem stage owns exceptions.
- stallreq_from_if = inst_req && !inst_done; stallreq_from_mem = data_req && !data_done (combinational).
- flush while owner=INST in ADDR or WAIT sets discard. The transaction still completes on the bus.
- Simultaneous data_req and inst_req in IDLE: data wins and the fetch waits.
- Minimum latency with addr_ok in the first ADDR cycle and data_ok one cycle later: request seen at cycle 0, done visible at cycle 3.
- Only one transaction is outstanding; no pipelining of addresses.

Optional Feature:
- Macro BUS_ARB_PERF_EN.
- Defined:
  - Adds 32-bit counters perf_inst_cnt, perf_data_cnt (completed, non-discarded transactions) and perf_stall_cnt (cycles where either stallreq is high).
  - Counters are exposed as output ports, reset to 0 and wrap at 2^32.
- Undefined: the counters and their ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header: state encodings ARB_IDLE/ARB_ADDR/ARB_WAIT, owner encodings OWN_INST/OWN_DATA, and size codes SIZE_BYTE/SIZE_HALF/SIZE_WORD.
- No sub-module is natural; the perf counters stay inline under the macro.

Test Plan:
- Fetch only: inst_req=1 at addr 0xBFC00000, addr_ok immediate, data_ok next cycle with rdata 0x3C080001 -> stallreq_from_if high for 3 cycles, then low with inst_rdata=0x3C080001.
- Both requests in the same cycle: store to 0x80000010 (wdata 0xDEADBEEF, size 2) plus a fetch -> bus sees the write first, the fetch second; stallreq_from_mem drops before stallreq_from_if.
- Flush in WAIT: fetch in flight, flush pulse -> data_ok arrives, inst_rdata unchanged, inst_done=0; the next fetch is issued normally.
- pipe_stall=1 held 4 cycles after data load completion -> data_done stays 1, no re-issue on the bus, data_rdata held; cleared one edge after pipe_stall falls.
- addr_ok delayed 5 cycles -> bus_req and bus fields stable throughout ADDR.
- resetn asserted in WAIT -> all outputs 0 immediately; after release a late bus_data_ok is ignored in IDLE.
